// File: rtl/decimal_entry_peripheral_pkg.sv
// Shared types and constants for the decimal entry peripheral and the signed decimal display.
package decimal_entry_peripheral_pkg;

  localparam int DIGIT_MAX = 9;
  localparam int ACC_W     = 30;

  typedef logic signed [31:0] data_t;

  // Listed in priority order: lower value wins when pulses coincide.
  typedef enum logic [1:0] {
    KEY_CLEAR = 2'd0,
    KEY_ENTER = 2'd1,
    KEY_NEG   = 2'd2,
    KEY_DIGIT = 2'd3
  } key_idx_e;

  function automatic data_t signed_entry(input logic [ACC_W-1:0] acc, input logic neg);
    data_t mag;
    mag = data_t'({{(32-ACC_W){1'b0}}, acc});
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/decimal_entry_peripheral_button_conditioner.sv
// Active-low push-button conditioner: 2-flop synchronizer, level debounce,
// one-cycle press pulse on an accepted 1->0 transition.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level disagrees with the stable level;
  // any agreement drops it back to zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        pulse_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = pulse_q;

endmodule

// File: rtl/decimal_entry_peripheral.sv
// Signed decimal keypad entry: builds acc = acc*10 + d from debounced buttons and
// hands the committed value to the CPU through a valid/rd handshake.
module decimal_entry_peripheral
  import decimal_entry_peripheral_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw,
  input  logic        key_digit_n,
  input  logic        key_neg_n,
  input  logic        key_enter_n,
  input  logic        key_clear_n,
  input  logic        rd,
  output logic [31:0] dout,
  output logic        valid,
  output logic [31:0] entry,
  output logic [3:0]  digit_count,
  output logic        err,
  output logic        lost
);

  logic [3:0] keys_n;
  logic [3:0] press;

  assign keys_n[KEY_CLEAR] = key_clear_n;
  assign keys_n[KEY_ENTER] = key_enter_n;
  assign keys_n[KEY_NEG]   = key_neg_n;
  assign keys_n[KEY_DIGIT] = key_digit_n;

  for (genvar i = 0; i < 4; i++) begin : g_key
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n_i (keys_n[i]),
      .press_o (press[i])
    );
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [3:0]       count_q, count_d;
  data_t            dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             lost_q, lost_d;
  data_t            entry_val;

  assign entry_val = signed_entry(acc_q, neg_q);

  // rd is applied first so that an enter in the same cycle can re-arm valid.
  always_comb begin
    acc_d   = acc_q;
    neg_d   = neg_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    err_d   = err_q;
    lost_d  = lost_q;
    if (rd) begin
      valid_d = 1'b0;
      lost_d  = 1'b0;
    end
    if (press[KEY_CLEAR]) begin
      acc_d   = '0;
      neg_d   = 1'b0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (press[KEY_ENTER]) begin
      if (!valid_q || rd) begin
        dout_d  = entry_val;
        valid_d = 1'b1;
        acc_d   = '0;
        neg_d   = 1'b0;
        count_d = '0;
      end else begin
        lost_d = 1'b1;
      end
    end else if (press[KEY_NEG]) begin
      neg_d = ~neg_q;
    end else if (press[KEY_DIGIT]) begin
      if ((sw <= 4'(DIGIT_MAX)) && (count_q < 4'(MAX_DIGITS))) begin
        acc_d   = (acc_q << 3) + (acc_q << 1) + ACC_W'(sw);
        count_d = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign dout        = dout_q;
  assign valid       = valid_q;
  assign entry       = entry_val;
  assign digit_count = count_q;
  assign err         = err_q;
  assign lost        = lost_q;

endmodule

// File: tb/tb_decimal_entry_peripheral.sv
// Directed bench for decimal_entry_peripheral with a short debounce window.
module tb_decimal_entry_peripheral;
  import decimal_entry_peripheral_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw;
  logic [3:0]  keys_n;
  logic        rd;
  logic [31:0] dout;
  logic        valid;
  logic [31:0] entry;
  logic [3:0]  digit_count;
  logic        err;
  logic        lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decimal_entry_peripheral #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .key_digit_n (keys_n[KEY_DIGIT]),
    .key_neg_n   (keys_n[KEY_NEG]),
    .key_enter_n (keys_n[KEY_ENTER]),
    .key_clear_n (keys_n[KEY_CLEAR]),
    .rd          (rd),
    .dout        (dout),
    .valid       (valid),
    .entry       (entry),
    .digit_count (digit_count),
    .err         (err),
    .lost        (lost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input key_idx_e k);
    keys_n[k] = 1'b0;
    tick(8);
    keys_n[k] = 1'b1;
    tick(8);
  endtask

  task automatic read_pulse();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    sw     = 4'd0;
    keys_n = 4'hF;
    rd     = 1'b0;
    tick(3);
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_entry", entry, 32'd0);
    chk("rst_count", {28'd0, digit_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_lost", {31'd0, lost}, 32'd0);
    rst_n = 1'b1;
    tick(3);

    // 1, 2, 3 then enter
    sw = 4'd1; press(KEY_DIGIT);
    sw = 4'd2; press(KEY_DIGIT);
    sw = 4'd3; press(KEY_DIGIT);
    chk("entry_123", entry, 32'd123);
    chk("count_3", {28'd0, digit_count}, 32'd3);
    press(KEY_ENTER);
    chk("dout_123", dout, 32'd123);
    chk("valid_after_enter", {31'd0, valid}, 32'd1);
    chk("entry_cleared", entry, 32'd0);
    chk("count_cleared", {28'd0, digit_count}, 32'd0);
    read_pulse();
    chk("valid_after_rd", {31'd0, valid}, 32'd0);

    // -45
    press(KEY_NEG);
    sw = 4'd4; press(KEY_DIGIT);
    sw = 4'd5; press(KEY_DIGIT);
    chk("entry_m45", entry, 32'hFFFFFFD3);
    press(KEY_ENTER);
    chk("dout_m45", dout, 32'hFFFFFFD3);
    chk("valid_m45", {31'd0, valid}, 32'd1);
    read_pulse();

    // nine nines, tenth rejected
    sw = 4'd9;
    repeat (9) press(KEY_DIGIT);
    chk("entry_9x9", entry, 32'd999999999);
    chk("count_9", {28'd0, digit_count}, 32'd9);
    chk("err_before_10th", {31'd0, err}, 32'd0);
    press(KEY_DIGIT);
    chk("entry_10th_kept", entry, 32'd999999999);
    chk("count_stays_9", {28'd0, digit_count}, 32'd9);
    chk("err_10th", {31'd0, err}, 32'd1);
    press(KEY_CLEAR);
    chk("err_cleared", {31'd0, err}, 32'd0);
    chk("entry_after_clear", entry, 32'd0);
    chk("count_after_clear", {28'd0, digit_count}, 32'd0);

    // invalid digit, then negative zero
    sw = 4'hB; press(KEY_DIGIT);
    chk("err_bad_digit", {31'd0, err}, 32'd1);
    chk("entry_bad_digit", entry, 32'd0);
    chk("count_bad_digit", {28'd0, digit_count}, 32'd0);
    press(KEY_NEG);
    chk("entry_neg_zero", entry, 32'd0);
    press(KEY_ENTER);
    chk("dout_neg_zero", dout, 32'd0);
    chk("valid_neg_zero", {31'd0, valid}, 32'd1);

    // enter dropped while valid
    sw = 4'd7; press(KEY_DIGIT);
    press(KEY_ENTER);
    chk("lost_set", {31'd0, lost}, 32'd1);
    chk("dout_unchanged", dout, 32'd0);
    chk("entry_kept", entry, 32'd7);
    chk("valid_held", {31'd0, valid}, 32'd1);

    // enter together with rd on the pulse cycle
    keys_n[KEY_ENTER] = 1'b0;
    tick(6);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    chk("dout_enter_rd", dout, 32'd7);
    chk("valid_enter_rd", {31'd0, valid}, 32'd1);
    chk("lost_cleared_rd", {31'd0, lost}, 32'd0);
    chk("entry_after_enter_rd", entry, 32'd0);
    keys_n[KEY_ENTER] = 1'b1;
    tick(8);

    // bounce: short lows never accepted
    sw = 4'd2;
    repeat (3) begin
      keys_n[KEY_DIGIT] = 1'b0;
      tick(3);
      keys_n[KEY_DIGIT] = 1'b1;
      tick(3);
    end
    tick(10);
    chk("bounce_count", {28'd0, digit_count}, 32'd0);
    chk("bounce_entry", entry, 32'd0);

    // held low 6 cycles: pulse 6 cycles after the edge, registers one later
    keys_n[KEY_DIGIT] = 1'b0;
    tick(6);
    chk("held_not_yet", {28'd0, digit_count}, 32'd0);
    keys_n[KEY_DIGIT] = 1'b1;
    tick(1);
    chk("held_accepted", {28'd0, digit_count}, 32'd1);
    tick(12);
    chk("held_single", {28'd0, digit_count}, 32'd1);
    chk("held_entry", entry, 32'd2);

    // clear and digit together
    sw = 4'd3;
    keys_n[KEY_CLEAR] = 1'b0;
    keys_n[KEY_DIGIT] = 1'b0;
    tick(8);
    keys_n[KEY_CLEAR] = 1'b1;
    keys_n[KEY_DIGIT] = 1'b1;
    tick(8);
    chk("prio_entry", entry, 32'd0);
    chk("prio_count", {28'd0, digit_count}, 32'd0);
    chk("prio_err", {31'd0, err}, 32'd0);

    // mid-entry async reset
    sw = 4'd5; press(KEY_DIGIT);
    press(KEY_ENTER);
    chk("pre_rst_lost", {31'd0, lost}, 32'd1);
    chk("pre_rst_entry", entry, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_entry", entry, 32'd0);
    chk("arst_count", {28'd0, digit_count}, 32'd0);
    chk("arst_lost", {31'd0, lost}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("post_rst_count", {28'd0, digit_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
